// File: rtl/digit_scan_rotator.sv
// Multiplexed-display digit scanner: drives one select line per dwell period,
// optionally blanks all selects between digits, and rotates through enabled digits.
module digit_scan_rotator #(
   parameter int NUM_DIGITS   = 8,
   parameter int DWELL_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          dir,
   input  logic [NUM_DIGITS-1:0]         digit_mask,
   output logic [NUM_DIGITS-1:0]         sel_out,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          blank,
   output logic                          scan_tick,
   output logic                          frame_done
);

   localparam int IDX_W   = $clog2(NUM_DIGITS);
   localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] LAST_POS   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic {
      ST_DWELL = 1'b0,
      ST_BLANK = 1'b1
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [IDX_W-1:0]  r_pos;
   logic              r_scan_tick;
   logic              r_frame_done;

   state_t            w_state_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_adv_req;
   logic              w_found;
   logic              w_wrap;
   logic [IDX_W-1:0]  w_next_pos;
   logic              w_do_adv;
   logic              w_active;
   logic [NUM_DIGITS-1:0] w_onehot;

   // State register: the only process that holds state.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         r_state      <= ST_DWELL;
         r_cnt        <= '0;
         r_pos        <= LAST_POS;
         r_scan_tick  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         if (w_do_adv) begin
            r_pos <= w_next_pos;
         end
         r_scan_tick  <= w_do_adv;
         r_frame_done <= w_do_adv & w_wrap;
      end
   end

   // Next-state logic; everything holds while enable is low.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_adv_req   = 1'b0;
      if (enable) begin
         unique case (r_state)
            ST_DWELL: begin
               if (r_cnt == DWELL_LAST) begin
                  w_cnt_nxt = '0;
                  if (BLANK_CYCLES > 0) begin
                     w_state_nxt = ST_BLANK;
                  end else begin
                     w_adv_req = 1'b1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            ST_BLANK: begin
               if (r_cnt == BLANK_LAST) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_DWELL;
                  w_adv_req   = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_state_nxt = ST_DWELL;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Next enabled digit, walking away from r_pos; offset NUM_DIGITS lands back
   // on r_pos, so the current digit is chosen only when it is the sole one set.
   always_comb begin : p_search
      int v_raw;
      int v_idx;
      w_found    = 1'b0;
      w_wrap     = 1'b0;
      w_next_pos = r_pos;
      v_raw      = 0;
      v_idx      = 0;
      for (int k = 1; k <= NUM_DIGITS; k++) begin
         v_raw = dir ? (int'(r_pos) + k) : (int'(r_pos) - k);
         if (v_raw < 0) begin
            v_idx = v_raw + NUM_DIGITS;
         end else if (v_raw >= NUM_DIGITS) begin
            v_idx = v_raw - NUM_DIGITS;
         end else begin
            v_idx = v_raw;
         end
         if (!w_found && digit_mask[v_idx[IDX_W-1:0]]) begin
            w_found    = 1'b1;
            w_next_pos = v_idx[IDX_W-1:0];
            w_wrap     = (v_raw < 0) || (v_raw >= NUM_DIGITS);
         end
      end
   end

   assign w_do_adv = w_adv_req & w_found;

   // Output decode uses the live mask so a digit disabled mid-dwell goes dark at once.
   always_comb begin
      w_onehot = '0;
      w_active = (r_state == ST_DWELL) && digit_mask[r_pos];
      if (w_active) begin
         w_onehot[r_pos] = 1'b1;
      end
      sel_out    = ACTIVE_LOW ? ~w_onehot : w_onehot;
      blank      = ~w_active;
      digit_idx  = r_pos;
      scan_tick  = r_scan_tick;
      frame_done = r_frame_done;
   end

endmodule

// File: tb/tb_digit_scan_rotator.sv
// Self-checking bench: two scanner configurations driven in parallel and compared
// each cycle against a list-based reference model, plus directed sequence checks.
module tb_digit_scan_rotator;

   localparam int N  = 8;
   localparam int DW = 4;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       dir;
   logic [7:0] mask;

   logic [7:0] sel_a, sel_b;
   logic [2:0] idx_a, idx_b;
   logic       blank_a, blank_b, tick_a, tick_b, frame_a, frame_b;

   int n_checks = 0;
   int n_fail   = 0;

   // Config 0: blanking, active-high selects. Config 1: no blanking, active-low.
   int cfg_blank [2] = '{2, 0};
   bit cfg_al    [2] = '{1'b0, 1'b1};

   bit m_dwell [2] = '{1'b1, 1'b1};
   int m_el    [2] = '{0, 0};
   int m_pos   [2] = '{7, 7};
   bit m_tick  [2] = '{1'b0, 1'b0};
   bit m_frame [2] = '{1'b0, 1'b0};

   digit_scan_rotator #(
      .NUM_DIGITS(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b0)
   ) u_dut_a (
      .clk(clk), .reset(reset), .enable(enable), .dir(dir), .digit_mask(mask),
      .sel_out(sel_a), .digit_idx(idx_a), .blank(blank_a),
      .scan_tick(tick_a), .frame_done(frame_a)
   );

   digit_scan_rotator #(
      .NUM_DIGITS(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(0), .ACTIVE_LOW(1'b1)
   ) u_dut_b (
      .clk(clk), .reset(reset), .enable(enable), .dir(dir), .digit_mask(mask),
      .sel_out(sel_b), .digit_idx(idx_b), .blank(blank_b),
      .scan_tick(tick_b), .frame_done(frame_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Next enabled digit from the sorted list of set mask bits.
   task automatic next_digit(input int cur, input bit up, input logic [7:0] msk,
                             output int nxt, output bit wrapped, output bit found);
      int lst[$];
      for (int i = 0; i < N; i++) if (msk[i]) lst.push_back(i);
      found   = (lst.size() > 0);
      nxt     = cur;
      wrapped = 1'b0;
      if (found) begin
         nxt = -1;
         if (up) begin
            foreach (lst[j]) if (nxt < 0 && lst[j] > cur) nxt = lst[j];
            if (nxt < 0) begin nxt = lst[0]; wrapped = 1'b1; end
         end else begin
            foreach (lst[j]) if (lst[j] < cur) nxt = lst[j];
            if (nxt < 0) begin nxt = lst[lst.size()-1]; wrapped = 1'b1; end
         end
      end
   endtask

   task automatic model_edge(input int c);
      int nxt, len;
      bit wr, fnd;
      m_tick[c]  = 1'b0;
      m_frame[c] = 1'b0;
      if (reset) begin
         m_dwell[c] = 1'b1;
         m_el[c]    = 0;
         m_pos[c]   = N - 1;
      end else if (enable) begin
         len = m_dwell[c] ? DW : cfg_blank[c];
         m_el[c]++;
         if (m_el[c] >= len) begin
            m_el[c] = 0;
            if (m_dwell[c] && cfg_blank[c] > 0) begin
               m_dwell[c] = 1'b0;
            end else begin
               m_dwell[c] = 1'b1;
               next_digit(m_pos[c], dir, mask, nxt, wr, fnd);
               if (fnd) begin
                  m_pos[c]   = nxt;
                  m_tick[c]  = 1'b1;
                  m_frame[c] = wr;
               end
            end
         end
      end
   endtask

   function automatic logic [7:0] exp_sel(input int c);
      logic [7:0] v = 8'h00;
      if (m_dwell[c] && mask[m_pos[c]]) v[m_pos[c]] = 1'b1;
      return cfg_al[c] ? ~v : v;
   endfunction

   function automatic logic exp_blank(input int c);
      return !(m_dwell[c] && mask[m_pos[c]]);
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      check("sel_a",   sel_a,   exp_sel(0));
      check("idx_a",   idx_a,   m_pos[0]);
      check("blank_a", blank_a, exp_blank(0));
      check("tick_a",  tick_a,  m_tick[0]);
      check("frame_a", frame_a, m_frame[0]);
      check("sel_b",   sel_b,   exp_sel(1));
      check("idx_b",   idx_b,   m_pos[1]);
      check("blank_b", blank_b, exp_blank(1));
      check("tick_b",  tick_b,  m_tick[1]);
      check("frame_b", frame_b, m_frame[1]);
   endtask

   initial begin : stimulus
      logic [7:0] exp28a [7] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h40};
      logic [7:0] exp28b [7] = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'hBF, 8'hBF, 8'hBF};
      int  seq[$];
      int  fr[$];
      bit  found;

      reset = 1'b1; enable = 1'b1; dir = 1'b0; mask = 8'hFF;
      step();
      step();
      reset = 1'b0;
      check("rst_idx_a", idx_a, 7);
      check("rst_blank_a", blank_a, 0);

      // Fresh reset, then dwell/blank/advance waveform for both configurations.
      reset = 1'b1; step(); reset = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (i > 0) step();
         check($sformatf("r28_sel_a[%0d]", i), sel_a, exp28a[i]);
         check($sformatf("r28_sel_b[%0d]", i), sel_b, exp28b[i]);
      end
      check("r28_tick_a", tick_a, 1);
      check("r28_blank_a_off", blank_a, 0);

      // Walk down to the 0 -> 7 wrap; config 1 must never go fully dark.
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         step();
         check("r33_not_dark_b", (sel_b == 8'hFF), 0);
         if (tick_a && idx_a == 3'd7) found = 1'b1;
      end
      check("r28_wrap_seen", found, 1);
      check("r28_wrap_frame", frame_a, 1);
      check("r28_wrap_sel", sel_a, 8'h80);

      // Sparse mask, descending.
      mask = 8'hA1; dir = 1'b0;
      reset = 1'b1; step(); reset = 1'b0;
      check("r29_start_idx", idx_a, 7);
      seq.delete(); fr.delete();
      for (int i = 0; i < 200 && seq.size() < 3; i++) begin
         step();
         if (tick_a) begin seq.push_back(int'(idx_a)); fr.push_back(int'(frame_a)); end
      end
      while (seq.size() < 3) begin seq.push_back(-1); fr.push_back(-1); end
      check("r29_idx1", seq[0], 5); check("r29_frame1", fr[0], 0);
      check("r29_idx2", seq[1], 0); check("r29_frame2", fr[1], 0);
      check("r29_idx3", seq[2], 7); check("r29_frame3", fr[2], 1);

      // Ascending from 7 wraps to 0 first.
      mask = 8'hFF; dir = 1'b1;
      reset = 1'b1; step(); reset = 1'b0;
      seq.delete(); fr.delete();
      for (int i = 0; i < 100 && seq.size() < 2; i++) begin
         step();
         if (tick_a) begin seq.push_back(int'(idx_a)); fr.push_back(int'(frame_a)); end
      end
      while (seq.size() < 2) begin seq.push_back(-1); fr.push_back(-1); end
      check("r30_idx1", seq[0], 0); check("r30_frame1", fr[0], 1);
      check("r30_idx2", seq[1], 1); check("r30_frame2", fr[1], 0);

      // Freeze after two dwell cycles; resume completes the dwell.
      dir = 1'b0;
      reset = 1'b1; step(); reset = 1'b0;
      step();
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("r31_frozen_sel", sel_a, 8'h80);
         check("r31_frozen_tick", tick_a, 0);
      end
      enable = 1'b1;
      step(); check("r31_resume1", sel_a, 8'h80);
      step(); check("r31_resume2", sel_a, 8'h80);
      step(); check("r31_blank_sel", sel_a, 8'h00);
      check("r31_blank_flag", blank_a, 1);

      // Empty mask: dark and silent.
      mask = 8'h00;
      for (int i = 0; i < 50; i++) begin
         step();
         check("r32_dark_sel", sel_a, 8'h00);
         check("r32_dark_blank", blank_a, 1);
         check("r32_no_tick", tick_a, 0);
      end

      // Reset landing in the middle of a blank interval.
      mask = 8'hFF;
      for (int i = 0; i < 20 && m_dwell[0]; i++) step();
      check("r32_in_blank", blank_a, 1);
      reset = 1'b1; step(); reset = 1'b0;
      check("r32_rst_idx", idx_a, 7);
      check("r32_rst_sel", sel_a, 8'h80);
      check("r32_rst_blank", blank_a, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         enable = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 29) == 0) dir = ~dir;
         if ($urandom_range(0, 39) == 0) begin
            case ($urandom_range(0, 3))
               0:       mask = 8'h00;
               1:       mask = 8'(1 << $urandom_range(0, 7));
               default: mask = 8'($urandom);
            endcase
         end
         reset = ($urandom_range(0, 199) == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/digit_scan_rotator.md
DIGIT_SCAN_ROTATOR -- requirements
Module: digit_scan_rotator

Interface
REQ-001: Parameter NUM_DIGITS, default 8, number of one-hot select lines; legal range 2..16.
REQ-002: Parameter DWELL_CYCLES, default 100000, enabled clk cycles each digit is driven; legal range >=1.
REQ-003: Parameter BLANK_CYCLES, default 1000, enabled clk cycles all selects are inactive between digits; legal range >=0.
REQ-004: Parameter ACTIVE_LOW, default 1; 1 = active select bit is 0, 0 = active select bit is 1.
REQ-005: clk  input  1  single clock; all state changes on its rising edge.
REQ-006: reset  input  1  synchronous, active-high reset.
REQ-007: enable  input  1  1 = scan advances; 0 = all state frozen.
REQ-008: dir  input  1  0 = index decrements (MSB toward LSB); 1 = index increments.
REQ-009: digit_mask  input  NUM_DIGITS  bit i = 1 means digit i takes part in the scan.
REQ-010: sel_out  output  NUM_DIGITS  one-hot (per ACTIVE_LOW) digit select.
REQ-011: digit_idx  output  $clog2(NUM_DIGITS)  index of the current digit, for the segment data mux.
REQ-012: blank  output  1  1 when no select bit is active.
REQ-013: scan_tick  output  1  one-cycle pulse on the first cycle a new digit is driven.
REQ-014: frame_done  output  1  one-cycle pulse, coincident with scan_tick, when the advance wraps.

Function
REQ-015: Two states: DWELL and BLANK; internal counter cnt and index pos.
REQ-016: DWELL with enable: cnt increments; at cnt == DWELL_CYCLES-1, cnt <= 0, then state <= BLANK if BLANK_CYCLES > 0, else an advance happens (REQ-018) and state stays DWELL.
REQ-017: BLANK with enable: cnt increments; at cnt == BLANK_CYCLES-1, cnt <= 0, state <= DWELL, advance happens.
REQ-018: Advance: pos <= first index with digit_mask bit set, searched from pos in direction dir with modulo-NUM_DIGITS wrap, excluding pos itself unless it is the only set bit; scan_tick = 1 in the next cycle.
REQ-019: frame_done = 1 with scan_tick when the advance crosses index 0 -> higher index (dir = 0) or NUM_DIGITS-1 -> lower index (dir = 1); includes the single-digit-mask case.
REQ-020: digit_mask all zero: no advance; pos holds; counting continues; scan_tick and frame_done stay 0.
REQ-021: sel_out = combinational decode of registered state/pos and live digit_mask: bit pos active only when state is DWELL and digit_mask[pos] = 1; otherwise all bits inactive. Inactive is 1 when ACTIVE_LOW = 1 and 0 otherwise.
REQ-022: blank = 1 exactly when sel_out has no active bit; digit_idx = pos at all times.
REQ-023: enable = 0: cnt, state, pos frozen; outputs hold; scan_tick and frame_done = 0. Counting resumes from the frozen cnt.
REQ-024: dir and digit_mask are sampled only at the advance; changing them mid-dwell does not restart cnt.
REQ-025: Steady enable with a full mask: each digit is active for DWELL_CYCLES cycles, then blank for BLANK_CYCLES cycles; period = DWELL_CYCLES + BLANK_CYCLES.

Reset
REQ-026: reset = 1 at a clk edge: state <= DWELL, cnt <= 0, pos <= NUM_DIGITS-1, scan_tick <= 0, frame_done <= 0; reset overrides enable and any in-progress dwell or blank.
REQ-027: First cycle after reset with a full mask: sel_out = 1000_0000 (ACTIVE_LOW = 0, 8 digits) or 0111_1111 (ACTIVE_LOW = 1), blank = 0.

Verification
Common settings: NUM_DIGITS = 8, DWELL_CYCLES = 4, BLANK_CYCLES = 2, ACTIVE_LOW = 0 unless stated.
REQ-028: Reset, mask FF, dir 0, enable 1 -> sel_out 1000_0000 for 4 cycles, then 0000_0000 for 2 cycles (blank = 1), then 0100_0000 with scan_tick; after 0000_0001 the next digit is 1000_0000 with frame_done = 1.
REQ-029: mask 1010_0001, dir 0 -> digit_idx sequence 7,5,0,7; frame_done only on the 0->7 step.
REQ-030: dir 1, mask FF -> digit_idx 7 then 0 (frame_done = 1) then 1.
REQ-031: enable dropped for 10 cycles after 2 dwell cycles -> sel_out frozen; after enable returns, 2 more dwell cycles, then blank.
REQ-032: mask 00 -> sel_out 0000_0000, blank = 1, no scan_tick for 50 cycles; reset asserted mid-BLANK -> next cycle pos = 7, DWELL, cnt = 0.
REQ-033: ACTIVE_LOW = 1, BLANK_CYCLES = 0 -> sel_out 0111_1111 for 4 cycles, then directly 1011_1111; never all-ones while the mask is FF.
